// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: single-clock byte FIFO between the UART receiver and the host.
// Registered pop output (one-clock read latency), occupancy count, empty/full/
// almost-full decodes and a sticky overflow flag. Note: rst_n is ACTIVE-HIGH
// and asynchronous despite its name; the port name is kept for compatibility.
module uart_rx_fifo #(
  parameter int DATA_WIDTH            = 8,
  parameter int FIFO_DEPTH            = 16,
  parameter int ALMOST_FULL_THRESHOLD = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          write_en,
  output logic [DATA_WIDTH-1:0]         read_data,
  input  logic                          read_en,
  input  logic                          fifo_clear,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          fifo_almost_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   data_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  overflow_q, overflow_d;

  logic                  do_write;
  logic                  do_read;

  // Status decodes come straight from the registered count.
  assign fifo_empty       = (count_q == '0);
  assign fifo_full        = (count_q == DEPTH_C);
  assign fifo_almost_full = (count_q >= AF_C);
  assign data_count       = count_q;
  assign read_data        = read_data_q;
  assign overflow         = overflow_q;

  // Next-state: clear wins over everything; full/empty gate write/read using
  // the pre-edge count, so a full FIFO still pops and an empty one still pushes.
  always_comb begin
    do_write    = write_en && !fifo_full  && !fifo_clear;
    do_read     = read_en  && !fifo_empty && !fifo_clear;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    overflow_d  = overflow_q;

    if (fifo_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (write_en && fifo_full) begin
        overflow_d = 1'b1;
      end
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        read_data_d = mem[rd_ptr_q];
      end
      case ({do_write, do_read})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised + directed bench for uart_rx_fifo with a queue-based reference
// model and a scoreboard monitor for popped data.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AF = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] write_data = '0;
  logic          write_en = 1'b0;
  logic [DW-1:0] read_data;
  logic          read_en = 1'b0;
  logic          fifo_clear = 1'b0;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          overflow;
  logic [4:0]    data_count;

  uart_rx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .ALMOST_FULL_THRESHOLD(AF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .write_data       (write_data),
    .write_en         (write_en),
    .read_data        (read_data),
    .read_en          (read_en),
    .fifo_clear       (fifo_clear),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .overflow         (overflow),
    .data_count       (data_count)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: contents as a queue, plus sticky flag and last popped byte.
  logic [DW-1:0] model_q[$];
  logic          model_ovf = 1'b0;
  logic [DW-1:0] model_rd  = '0;
  // Scoreboard of bytes the monitor should see appear on read_data.
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"}, 32'(data_count), 32'(n));
    check({tag, ".empty"}, 32'(fifo_empty), 32'(n == 0));
    check({tag, ".full"},  32'(fifo_full),  32'(n == D));
    check({tag, ".afull"}, 32'(fifo_almost_full), 32'(n >= AF));
    check({tag, ".ovf"},   32'(overflow),   32'(model_ovf));
    check({tag, ".rdata"}, 32'(read_data),  32'(model_rd));
  endtask

  // One clock of stimulus: drive on the falling edge, update the model at the
  // rising edge, check status just after it.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                      input logic clr, input string tag);
    int n;
    @(negedge clk);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    fifo_clear = clr;
    @(posedge clk);
    n = model_q.size();
    if (clr) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (re && n > 0) begin
        model_rd = model_q.pop_front();
        exp_q.push_back(model_rd);
      end
      if (we) begin
        if (n == D) model_ovf = 1'b1;
        else        model_q.push_back(wd);
      end
    end
    #1;
    check_status(tag);
  endtask

  // Monitor: whenever a pop handshake is presented (read_en with a non-empty,
  // non-clearing FIFO), the byte on read_data after the edge must be the
  // oldest outstanding scoreboard entry.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n && read_en && !fifo_empty && !fifo_clear) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL sb_unexpected_pop: got 0x%0h expected no pop at %0t", read_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_pop", 32'(read_data), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] hold;
    int wp, rp;

    repeat (3) @(negedge clk);
    #1;
    check_status("reset");
    rst_n = 1'b0;

    // Single byte round trip.
    step(1'b1, 8'hA5, 1'b0, 1'b0, "wa5");
    step(1'b0, 8'h00, 1'b0, 1'b0, "idle1");
    check("one.count", 32'(data_count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, "rd_a5");
    check("rd_a5.value", 32'(read_data), 32'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0, "hold1");
    step(1'b0, 8'h00, 1'b0, 1'b0, "hold2");
    check("rd_a5.hold", 32'(read_data), 32'hA5);
    check("rd_a5.empty", 32'(fifo_empty), 32'd1);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    check("fill.full", 32'(fifo_full), 32'd1);
    check("fill.ovf0", 32'(overflow), 32'd0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, "ovf");
    check("ovf.set", 32'(overflow), 32'd1);
    check("ovf.count", 32'(data_count), 32'd16);

    // Drain with separate pulses; overflow must survive reads.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      check("drain.order", 32'(read_data), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b0, "drain_gap");
    end
    check("drain.ovf_sticky", 32'(overflow), 32'd1);

    // Clear flushes contents and overflow; read_data holds.
    for (int i = 'h10; i <= 'h14; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "pre_clr");
    hold = read_data;
    step(1'b1, 8'h77, 1'b1, 1'b1, "clear");
    check("clear.ovf", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, "rd_after_clr");
    check("clear.rd_hold", 32'(read_data), 32'(hold));

    // Almost-full threshold boundary.
    for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "af_fill");
    check("af.below", 32'(fifo_almost_full), 32'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, "af_hit");
    check("af.at", 32'(fifo_almost_full), 32'd1);

    // Simultaneous push/pop at count 5 across pointer wrap.
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 14; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "wrap_fill");
    for (int i = 0; i < 9; i++)  step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
    for (int i = 0; i < 3; i++)  step(1'b1, 8'($urandom), 1'b1, 1'b0, "rw");
    check("rw.count", 32'(data_count), 32'd5);
    for (int i = 0; i < 3; i++)  step(1'b1, 8'($urandom), 1'b1, 1'b0, "rw2");

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b1;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    model_rd  = '0;
    check("arst.count", 32'(data_count), 32'd0);
    check("arst.empty", 32'(fifo_empty), 32'd1);
    check("arst.rdata", 32'(read_data), 32'd0);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    #1;
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, "post_arst");

    // Random traffic in write-heavy / read-heavy / balanced phases.
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       begin wp = 80; rp = 25; end
        1:       begin wp = 25; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      for (int k = 0; k < 150; k++) begin
        step(($urandom % 100) < wp, 8'($urandom), ($urandom % 100) < rp,
             ($urandom % 60) == 0, "rand");
      end
    end

    // Drain what remains so every scoreboard entry gets compared.
    for (int i = 0; i < D + 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "final_drain");
    step(1'b0, 8'h00, 1'b0, 1'b0, "final_idle");
    check("sb.leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synchronous single-clock FIFO that buffers bytes received by the UART receiver until the host or register interface reads them. It provides empty, full and almost-full status, a live occupancy count, and a sticky overflow flag for writes attempted while full. Reads are registered, so data appears one clock after the read request.

Parameters:
DATA_WIDTH, 8, width of each stored word.
FIFO_DEPTH, 16, number of entries; must be a power of two and at least 2.
ALMOST_FULL_THRESHOLD, 12, occupancy at or above which fifo_almost_full asserts; range 1..FIFO_DEPTH.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst_n  input  1  reset; asynchronous and active-high (asserted = 1), despite the port name.
write_data  input  DATA_WIDTH  word to push.
write_en  input  1  push request, sampled each rising edge.
read_data  output  DATA_WIDTH  registered pop output.
read_en  input  1  pop request, sampled each rising edge.
fifo_clear  input  1  synchronous flush.
fifo_empty  output  1  high when data_count == 0.
fifo_full  output  1  high when data_count == FIFO_DEPTH.
fifo_almost_full  output  1  high when data_count >= ALMOST_FULL_THRESHOLD.
overflow  output  1  sticky flag: a write was attempted while the FIFO was full.
data_count  output  $clog2(FIFO_DEPTH)+1  current number of stored entries, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n=1, asynchronous): read/write pointers=0, data_count=0, read_data=0, overflow=0, so fifo_empty=1, fifo_full=0, fifo_almost_full=0. Storage array is not reset.
- fifo_empty, fifo_full and fifo_almost_full are combinational decodes of the registered data_count.
- Write: if write_en=1 and not full, store write_data at the write pointer on the edge, advance the pointer modulo FIFO_DEPTH, and increment the count.
- Write while full: the data is dropped, the pointer and count are unchanged, and overflow is set to 1.
- overflow stays set until fifo_clear or reset. A read does not clear it.
- Read: if read_en=1 and not empty, read_data is loaded with the entry at the read pointer on that edge, the pointer advances modulo FIFO_DEPTH, and the count decrements. Latency is one clock; the value persists until the next successful read.
- Read while empty: ignored. read_data holds its value and the count stays 0.
- Simultaneous read and write, neither blocked:
  - both complete and data_count is unchanged;
  - when empty, the write proceeds and the read is ignored;
  - when full, the read proceeds and the write is dropped with overflow set.
- fifo_clear=1 (synchronous) has priority over read and write in the same cycle:
  - pointers and data_count go to 0, and overflow goes to 0;
  - read_data holds its value;
  - a write or read in the same cycle is discarded.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. data_count is the authoritative occupancy and is never allowed outside 0..FIFO_DEPTH.

Test Plan:
- Reset, write 0xA5, idle one cycle -> fifo_empty=0, data_count=1. Pulse read_en one cycle -> read_data=0xA5 after the edge and still 0xA5 two cycles later; data_count=0, fifo_empty=1.
- Write 0x00..0x0F in 16 writes -> fifo_full=1, fifo_almost_full=1, data_count=16, overflow=0. Write 0xFF -> overflow=1 and data_count stays 16.
- From the previous full state, issue 16 separate read pulses -> read_data=0x00..0x0F in order (one-cycle latency). Afterwards fifo_empty=1 and overflow still 1.
- Write 0x10..0x14, pulse fifo_clear -> data_count=0, fifo_empty=1, overflow=0. An extra read leaves read_data unchanged.
- Write 11 entries -> fifo_almost_full=0. Write 0xAA -> data_count=12 and fifo_almost_full=1.
- With count=5, assert read_en and write_en together for 3 cycles -> count stays 5 and FIFO order is preserved across pointer wrap. Asserting rst_n mid-sequence immediately forces count=0, empty=1, read_data=0.
